// File: rtl/dtw_mem_pkg.sv
// dtw_mem_pkg: shared widths and bus-op encoding for the DTW working memory.
`default_nettype none

package dtw_mem_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;

  localparam logic [1:0] OP_IDLE  = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_TURN  = 2'd3;

  typedef struct packed {
    logic cs_n;
    logic wr;
  } pin_ctl_t;

  // TURN is a dummy read, so it asserts CS with WR low just like READ.
  function automatic pin_ctl_t op_pins(input logic [1:0] op);
    pin_ctl_t p;
    p.cs_n = (op == OP_IDLE);
    p.wr   = (op == OP_WRITE);
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb_pick.sv
// arb_pick: 2-way grant selector; round-robin pointer when ARB_RR_EN is
// defined, fixed priority (requester 0 first) otherwise.
`default_nettype none

module arb_pick (
  input  logic       clk,
  input  logic       nrst,
  input  logic [1:0] elig_i,
  output logic [1:0] gnt_o
);

`ifdef ARB_RR_EN
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = elig_i;
    if (&elig_i) gnt_o = ptr_q ? 2'b10 : 2'b01;
  end

  // Pointer always moves to whoever lost (or did not ask) this cycle.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_o[0])      ptr_d = 1'b1;
    else if (gnt_o[1]) ptr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
`else
  logic unused_w;
  assign unused_w = clk ^ nrst;

  always_comb begin
    gnt_o = 2'b00;
    if (elig_i[0])      gnt_o = 2'b01;
    else if (elig_i[1]) gnt_o = 2'b10;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port working memory between template fetch
// (r0) and writeback (r1); ARB_RR_EN selects round-robin over fixed priority.
`default_nettype none

module mem_arbiter
  import dtw_mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          r0_req,
  input  logic          r0_wr,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  input  logic          r1_req,
  input  logic          r1_wr,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r0_gnt,
  output logic          r1_gnt,
  output logic          r0_rvalid,
  output logic          r1_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  inout  wire  [DW-1:0] mem_data,
  output logic          mem_WR,
  output logic          mem_CS
);

  logic [1:0]    op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  pin_ctl_t      pins_q, pins_d;
  logic          rv1_q, rv1_d, own1_q, own1_d;
  logic          rv2_q, own2_q;
  logic [1:0]    rvalid_q;
  logic [DW-1:0] rdata_q;

  logic [1:0]    elig_w, pick_w, gnt_w;
  logic          sel_wr_w;
  logic [AW-1:0] sel_addr_w;
  logic [DW-1:0] sel_wdata_w;

  // A write right after a READ would collide with the memory's read data.
  assign elig_w[0] = r0_req & ((op_q != OP_READ) | ~r0_wr);
  assign elig_w[1] = r1_req & ((op_q != OP_READ) | ~r1_wr);

  arb_pick u_pick (
    .clk    (clk),
    .nrst   (nrst),
    .elig_i (elig_w),
    .gnt_o  (pick_w)
  );

  assign gnt_w  = pick_w & {2{nrst}};
  assign r0_gnt = gnt_w[0];
  assign r1_gnt = gnt_w[1];

  assign sel_wr_w    = gnt_w[1] ? r1_wr    : r0_wr;
  assign sel_addr_w  = gnt_w[1] ? r1_addr  : r0_addr;
  assign sel_wdata_w = gnt_w[1] ? r1_wdata : r0_wdata;

  always_comb begin
    op_d    = (op_q == OP_READ) ? OP_TURN : OP_IDLE;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rv1_d   = 1'b0;
    own1_d  = 1'b0;
    if (|gnt_w) begin
      op_d    = sel_wr_w ? OP_WRITE : OP_READ;
      addr_d  = sel_addr_w;
      wdata_d = sel_wdata_w;
      rv1_d   = ~sel_wr_w;
      own1_d  = gnt_w[1];
    end
    pins_d = op_pins(op_d);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      op_q        <= OP_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      pins_q.cs_n <= 1'b1;
      pins_q.wr   <= 1'b0;
      rv1_q       <= 1'b0;
      own1_q      <= 1'b0;
      rv2_q       <= 1'b0;
      own2_q      <= 1'b0;
      rvalid_q    <= 2'b00;
      rdata_q     <= '0;
    end else begin
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      pins_q   <= pins_d;
      rv1_q    <= rv1_d;
      own1_q   <= own1_d;
      rv2_q    <= rv1_q;
      own2_q   <= own1_q;
      rvalid_q <= rv2_q ? (own2_q ? 2'b10 : 2'b01) : 2'b00;
      if (rv2_q) rdata_q <= mem_data;
    end
  end

  assign mem_CS    = pins_q.cs_n;
  assign mem_WR    = pins_q.wr;
  assign mem_addr  = addr_q;
  assign mem_data  = (!pins_q.cs_n && pins_q.wr) ? wdata_q : {DW{1'bz}};
  assign rdata     = rdata_q;
  assign r0_rvalid = rvalid_q[0];
  assign r1_rvalid = rvalid_q[1];

endmodule

`default_nettype wire
